// File: rtl/mt9v034_stereo_unpacker.sv
// Unpacks MT9V034 stereo words from the LVDS receiver into an AXI4-Stream of 16-bit pixel pairs.
// Stage 1 registers and classifies each word; stage 2 runs the frame/line FSM and feeds a small FWFT FIFO.
module mt9v034_stereo_unpacker #(
  parameter logic [7:0] FS_CODE    = 8'hFF,
  parameter logic [7:0] LS_CODE    = 8'hFE,
  parameter logic [7:0] LE_CODE    = 8'hFD,
  parameter logic [7:0] FE_CODE    = 8'hFC,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [17:0] rx_data,
  input  logic        rx_data_rdy,
  input  logic        rx_data_locked,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        in_frame,
  output logic [15:0] frame_count,
  output logic [15:0] line_length,
  output logic        err_framing,
  output logic        err_sync,
  output logic        err_overflow,
  input  logic        err_clear
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_FS, FRAME, LINE, DROP} state_t;
  typedef enum logic [2:0] {K_PIX, K_FS, K_LS, K_LE, K_FE} kind_t;

  function automatic kind_t classify(input logic [7:0] m, input logic [7:0] s);
    kind_t k;
    k = K_PIX;
    if (m == s) begin
      if (m == FS_CODE)      k = K_FS;
      else if (m == LS_CODE) k = K_LS;
      else if (m == LE_CODE) k = K_LE;
      else if (m == FE_CODE) k = K_FE;
    end
    return k;
  endfunction

  logic        s1_valid;
  logic        s1_bad;
  kind_t       s1_kind;
  logic [15:0] s1_pix;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_valid <= 1'b0;
      s1_bad   <= 1'b0;
      s1_kind  <= K_PIX;
      s1_pix   <= '0;
    end else begin
      s1_valid <= rx_data_rdy;
      if (rx_data_rdy) begin
        s1_bad  <= !rx_data[17] || rx_data[0];
        s1_pix  <= rx_data[16:1];
        s1_kind <= classify(rx_data[16:9], rx_data[8:1]);
      end
    end
  end

  state_t      state;
  logic        pend_valid;
  logic [15:0] pend_data;
  logic        pend_user;
  logic        sof_armed;
  logic [15:0] pix_count;
  logic        push_req;
  logic        push_soft;
  logic        push_last;
  logic        push_user;
  logic [15:0] push_data;

  logic [17:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push_ok;
  logic        overflow;
  logic        word_ok;
  logic        lock_lost;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && m_axis_tready;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign overflow   = push_req && !push_soft && fifo_full && !pop;
  assign word_ok    = s1_valid && !s1_bad;
  assign lock_lost  = !rx_data_locked && (state != IDLE);

  // The pending pixel waits here until the next word tells us whether it ends the line.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_data   <= '0;
      pend_user   <= 1'b0;
      sof_armed   <= 1'b0;
      pix_count   <= '0;
      line_length <= '0;
      frame_count <= '0;
      in_frame    <= 1'b0;
      err_sync    <= 1'b0;
      err_framing <= 1'b0;
      push_req    <= 1'b0;
      push_soft   <= 1'b0;
      push_last   <= 1'b0;
      push_user   <= 1'b0;
      push_data   <= '0;
    end else begin
      push_req  <= 1'b0;
      push_soft <= 1'b0;
      push_last <= 1'b0;
      push_data <= pend_data;
      push_user <= pend_user;
      if (err_clear) begin
        err_sync    <= 1'b0;
        err_framing <= 1'b0;
      end
      if (s1_valid && s1_bad) err_framing <= 1'b1;

      if (lock_lost) begin
        state      <= IDLE;
        in_frame   <= 1'b0;
        pend_valid <= 1'b0;
        sof_armed  <= 1'b0;
        push_req   <= pend_valid;
        push_soft  <= 1'b1;
        push_last  <= 1'b1;
        if (state == LINE || state == FRAME) err_sync <= 1'b1;
      end else if (overflow) begin
        state      <= DROP;
        in_frame   <= 1'b0;
        pend_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rx_data_locked) state <= WAIT_FS;
          WAIT_FS, DROP: begin
            if (word_ok && s1_kind == K_FS) begin
              state     <= FRAME;
              in_frame  <= 1'b1;
              sof_armed <= 1'b1;
            end
          end
          FRAME: begin
            if (word_ok) begin
              case (s1_kind)
                K_FS: begin
                  err_sync  <= 1'b1;
                  sof_armed <= 1'b1;
                end
                K_LS: begin
                  state     <= LINE;
                  pix_count <= '0;
                end
                K_FE: begin
                  state       <= WAIT_FS;
                  in_frame    <= 1'b0;
                  frame_count <= frame_count + 16'd1;
                end
                default: err_sync <= 1'b1;
              endcase
            end
          end
          LINE: begin
            if (word_ok && s1_kind == K_PIX) begin
              push_req   <= pend_valid;
              pend_valid <= 1'b1;
              pend_data  <= s1_pix;
              pend_user  <= sof_armed;
              sof_armed  <= 1'b0;
              if (pix_count != 16'hFFFF) pix_count <= pix_count + 16'd1;
            end else if (word_ok) begin
              // Any code closes the line; only LE is a clean close.
              push_req   <= pend_valid;
              push_last  <= 1'b1;
              pend_valid <= 1'b0;
              state      <= FRAME;
              case (s1_kind)
                K_LE: line_length <= pix_count;
                K_FS: begin
                  err_sync  <= 1'b1;
                  sof_armed <= 1'b1;
                end
                K_LS: begin
                  err_sync  <= 1'b1;
                  state     <= LINE;
                  pix_count <= '0;
                end
                default: begin
                  err_sync    <= 1'b1;
                  state       <= WAIT_FS;
                  in_frame    <= 1'b0;
                  frame_count <= frame_count + 16'd1;
                end
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // First-word-fall-through FIFO; a soft push (lock-loss flush) is silently lost when full.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= {push_user, push_last, push_data};
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (err_clear) err_overflow <= 1'b0;
      if (overflow)  err_overflow <= 1'b1;
    end
  end

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem[rd_ptr[AW-1:0]];
  assign m_axis_tvalid = !fifo_empty;

endmodule
